// File: rtl/if_fetch_queue_if.sv
// Purpose : fetch-to-decode bus; head instruction and its PC with valid/ready.
// Latency : wires only, no storage.
// Backpressure: the slave holds id_ready low to keep the head entry in place.
// Ports   : id_valid/id_ir/id_pc driven by the fetch queue, id_ready by ID.
interface if_fetch_queue_if #(
    parameter int PC_W = 8,
    parameter int IR_W = 16
);
    logic            id_valid;
    logic            id_ready;
    logic [IR_W-1:0] id_ir;
    logic [PC_W-1:0] id_pc;

    modport master (output id_valid, output id_ir, output id_pc, input id_ready);
    modport slave  (input id_valid, input id_ir, input id_pc, output id_ready);
endinterface

// File: rtl/if_fetch_queue.sv
// Purpose : instruction fetch with branch redirect and a DEPTH-entry queue to ID.
// Latency : ROM word appears on id_* one cycle after its address is on i_addr.
// Backpressure: id_ready low fills the queue; when full, pc holds and fetch stalls.
// Ports   : clock/reset (async active-low), enable, ROM (i_addr/i_datain),
//           MEM-stage branch inputs (mem_valid/mem_ir/reg_C/zf/nf/cf),
//           redirect, full, and the ID bus (id_bus master modport).
module if_fetch_queue #(
    parameter int              PC_W     = 8,
    parameter int              IR_W     = 16,
    parameter int              OP_W     = 5,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [IR_W-1:0] NOP      = '0,
    parameter logic [OP_W-1:0] OP_BZ    = OP_W'(16),
    parameter logic [OP_W-1:0] OP_BN    = OP_W'(17),
    parameter logic [OP_W-1:0] OP_BC    = OP_W'(18),
    parameter logic [OP_W-1:0] OP_BNZ   = OP_W'(19),
    parameter logic [OP_W-1:0] OP_BNN   = OP_W'(20),
    parameter logic [OP_W-1:0] OP_BNC   = OP_W'(21),
    parameter logic [OP_W-1:0] OP_JUMP  = OP_W'(22),
    parameter logic [OP_W-1:0] OP_JMPR  = OP_W'(23)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [IR_W-1:0] i_datain,
    output logic [PC_W-1:0] i_addr,
    input  logic            mem_valid,
    input  logic [IR_W-1:0] mem_ir,
    input  logic [IR_W-1:0] reg_C,
    input  logic            zf,
    input  logic            nf,
    input  logic            cf,
    output logic            redirect,
    output logic            full,
    if_fetch_queue_if.master id_bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  ent_pc_q [DEPTH];
    logic [IR_W-1:0]  ent_ir_q [DEPTH];

    logic [OP_W-1:0]  op;
    logic             cond;
    logic             taken;
    logic             head_vld;
    logic             push;
    logic             pop;
    logic             wr_en;

    // Only the target's low bits and the opcode field of mem_ir are meaningful.
    logic unused_bits;
    assign unused_bits = ^{reg_C[IR_W-1:PC_W], mem_ir[IR_W-OP_W-1:0]};

    assign op = mem_ir[IR_W-1 -: OP_W];

    always_comb begin
        cond = 1'b0;
        if (op == OP_JUMP || op == OP_JMPR) cond = 1'b1;
        if (op == OP_BZ  &&  zf)            cond = 1'b1;
        if (op == OP_BNZ && !zf)            cond = 1'b1;
        if (op == OP_BN  &&  nf)            cond = 1'b1;
        if (op == OP_BNN && !nf)            cond = 1'b1;
        if (op == OP_BC  &&  cf)            cond = 1'b1;
        if (op == OP_BNC && !cf)            cond = 1'b1;
    end

    // Branch resolution is independent of queue occupancy.
    assign taken    = enable & mem_valid & cond;
    assign redirect = taken;

    assign i_addr   = pc_q;
    assign head_vld = (cnt_q != '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign push     = ~full;
    assign pop      = head_vld & id_bus.id_ready;

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        if (taken) begin
            // Flush squashes the head even when ID is ready for it.
            pc_d     = reg_C[PC_W-1:0];
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else if (enable) begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + PC_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset: it is only observed while cnt_q is non-zero.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            ent_pc_q[wr_ptr_q] <= pc_q;
            ent_ir_q[wr_ptr_q] <= i_datain;
        end
    end

    assign id_bus.id_valid = head_vld;
    assign id_bus.id_ir    = head_vld ? ent_ir_q[rd_ptr_q] : NOP;
    assign id_bus.id_pc    = head_vld ? ent_pc_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
    localparam int         PC_W  = 8;
    localparam int         IR_W  = 16;
    localparam int         DEPTH = 4;
    localparam logic [4:0] BZ = 5'd16, BN = 5'd17, BC = 5'd18, BNZ = 5'd19;
    localparam logic [4:0] BNN = 5'd20, BNC = 5'd21, JUMP = 5'd22, JMPR = 5'd23;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [IR_W-1:0] i_datain;
    logic [PC_W-1:0] i_addr;
    logic            mem_valid = 1'b0;
    logic [IR_W-1:0] mem_ir = '0;
    logic [IR_W-1:0] reg_C = '0;
    logic            zf = 1'b0, nf = 1'b0, cf = 1'b0;
    logic            redirect;
    logic            full;

    if_fetch_queue_if #(.PC_W(PC_W), .IR_W(IR_W)) idb ();

    if_fetch_queue #(
        .PC_W(PC_W), .IR_W(IR_W), .OP_W(5), .DEPTH(DEPTH),
        .RESET_PC(8'h00), .NOP(16'h0000),
        .OP_BZ(BZ), .OP_BN(BN), .OP_BC(BC), .OP_BNZ(BNZ),
        .OP_BNN(BNN), .OP_BNC(BNC), .OP_JUMP(JUMP), .OP_JMPR(JMPR)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .i_datain(i_datain), .i_addr(i_addr),
        .mem_valid(mem_valid), .mem_ir(mem_ir), .reg_C(reg_C),
        .zf(zf), .nf(nf), .cf(cf),
        .redirect(redirect), .full(full),
        .id_bus(idb)
    );

    always #5 clock = ~clock;

    // Asynchronous ROM: word at address a is 0x1000 + a.
    assign i_datain = 16'h1000 + IR_W'(i_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PC_W-1:0] pc;
        logic [IR_W-1:0] ir;
    } ent_t;

    ent_t            m_q[$];
    logic [PC_W-1:0] m_pc = '0;

    function automatic bit m_taken(input logic en, input logic mv, input logic [IR_W-1:0] ir,
                                   input logic z, input logic n, input logic c);
        logic [4:0] o;
        o = ir[15:11];
        return en && mv && (o == JUMP || o == JMPR ||
                            (o == BZ && z) || (o == BNZ && !z) ||
                            (o == BN && n) || (o == BNN && !n) ||
                            (o == BC && c) || (o == BNC && !c));
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc = '0;
            m_q.delete();
        end else if (enable) begin
            if (m_taken(enable, mem_valid, mem_ir, zf, nf, cf)) begin
                m_pc = reg_C[PC_W-1:0];
                m_q.delete();
            end else begin
                bit was_full;
                was_full = (m_q.size() == DEPTH);
                if (m_q.size() != 0 && idb.id_ready) void'(m_q.pop_front());
                if (!was_full) begin
                    m_q.push_back('{pc: m_pc, ir: 16'h1000 + IR_W'(m_pc)});
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model, sampled 1 time unit after negedge.
    always @(negedge clock) begin
        logic            e_vld;
        logic [IR_W-1:0] e_ir;
        logic [PC_W-1:0] e_pc;
        #1;
        e_vld = (m_q.size() != 0);
        e_ir  = e_vld ? m_q[0].ir : 16'h0000;
        e_pc  = e_vld ? m_q[0].pc : 8'h00;
        check("m_i_addr",   32'(i_addr),       32'(m_pc));
        check("m_id_valid", 32'(idb.id_valid), 32'(e_vld));
        check("m_id_ir",    32'(idb.id_ir),    32'(e_ir));
        check("m_id_pc",    32'(idb.id_pc),    32'(e_pc));
        check("m_full",     32'(full),         32'(m_q.size() == DEPTH));
        check("m_redirect", 32'(redirect),
              32'(m_taken(enable, mem_valid, mem_ir, zf, nf, cf)));
    end

    // ---------------- directed stimulus with literal expectations ----------------
    logic [4:0] ops [9] = '{BZ, BN, BC, BNZ, BNN, BNC, JUMP, JMPR, 5'd0};

    initial begin
        idb.id_ready = 1'b0;
        #12;
        check("rst_i_addr", 32'(i_addr), 32'h00);
        check("rst_valid",  32'(idb.id_valid), 32'h0);
        check("rst_ir",     32'(idb.id_ir), 32'h0000);
        check("rst_pc",     32'(idb.id_pc), 32'h00);
        check("rst_full",   32'(full), 32'h0);
        reset = 1'b1; enable = 1'b1; idb.id_ready = 1'b1;

        // Streaming fetch with ID always ready.
        @(negedge clock); #2;
        check("s0_ir", 32'(idb.id_ir), 32'h1000);
        check("s0_pc", 32'(idb.id_pc), 32'h00);
        check("s0_addr", 32'(i_addr), 32'h01);
        @(negedge clock); #2;
        check("s1_ir", 32'(idb.id_ir), 32'h1001);
        check("s1_pc", 32'(idb.id_pc), 32'h01);
        check("s1_addr", 32'(i_addr), 32'h02);
        reset = 1'b0;

        // Fill the queue with ID stalled.
        @(negedge clock); #2;
        check("rst2_valid", 32'(idb.id_valid), 32'h0);
        reset = 1'b1; idb.id_ready = 1'b0;
        repeat (6) @(negedge clock);
        #2;
        check("fill_full", 32'(full), 32'h1);
        check("fill_addr", 32'(i_addr), 32'h04);
        check("fill_ir",   32'(idb.id_ir), 32'h1000);
        idb.id_ready = 1'b1;
        @(negedge clock); #2;
        check("pop_full", 32'(full), 32'h0);
        check("pop_pc",   32'(idb.id_pc), 32'h01);
        check("pop_addr", 32'(i_addr), 32'h04);
        idb.id_ready = 1'b0;
        @(negedge clock); #2;
        check("refill_full", 32'(full), 32'h1);
        check("refill_addr", 32'(i_addr), 32'h05);
        idb.id_ready = 1'b1;

        // Taken BZ with three entries queued; head squashed despite id_ready.
        @(negedge clock); #2;
        check("pre_br_pc", 32'(idb.id_pc), 32'h02);
        mem_valid = 1'b1; mem_ir = {BZ, 11'h123}; zf = 1'b1; reg_C = 16'h0040;
        #1;
        check("bz_redirect", 32'(redirect), 32'h1);
        @(negedge clock); #2;
        check("br_flush_valid", 32'(idb.id_valid), 32'h0);
        check("br_addr", 32'(i_addr), 32'h40);
        check("br_nop", 32'(idb.id_ir), 32'h0000);
        mem_valid = 1'b0; idb.id_ready = 1'b0;
        @(negedge clock); #2;
        check("br_first_pc", 32'(idb.id_pc), 32'h40);
        check("br_first_ir", 32'(idb.id_ir), 32'h1040);

        // Not-taken cases.
        idb.id_ready = 1'b1; mem_valid = 1'b1; mem_ir = {BNZ, 11'h0}; zf = 1'b1;
        #1; check("bnz_nt", 32'(redirect), 32'h0);
        @(negedge clock); #2;
        mem_ir = {BC, 11'h0}; cf = 1'b0; zf = 1'b0;
        #1; check("bc_nt", 32'(redirect), 32'h0);
        @(negedge clock); #2;
        mem_ir = {BZ, 11'h0}; zf = 1'b1; mem_valid = 1'b0;
        #1; check("bz_squashed_nt", 32'(redirect), 32'h0);
        @(negedge clock); #2;
        check("nt_addr", 32'(i_addr), 32'h44);
        check("nt_pc", 32'(idb.id_pc), 32'h43);

        // Jump to 0xFF with truncated upper target bits, then wrap.
        mem_valid = 1'b1; mem_ir = {JUMP, 11'h0}; reg_C = 16'hABFF;
        #1; check("jmp_redirect", 32'(redirect), 32'h1);
        @(negedge clock); #2;
        check("jmp_addr", 32'(i_addr), 32'hFF);
        mem_valid = 1'b0;
        @(negedge clock); #2;
        check("wrap_addr", 32'(i_addr), 32'h00);
        check("wrap_pc", 32'(idb.id_pc), 32'hFF);
        check("wrap_ir", 32'(idb.id_ir), 32'h10FF);

        // Disabled: nothing moves, branch not resolved.
        enable = 1'b0; mem_valid = 1'b1; mem_ir = {JUMP, 11'h0}; reg_C = 16'h0077;
        #1; check("dis_redirect", 32'(redirect), 32'h0);
        repeat (3) @(negedge clock);
        #2;
        check("dis_addr", 32'(i_addr), 32'h00);
        check("dis_pc", 32'(idb.id_pc), 32'hFF);
        check("dis_valid", 32'(idb.id_valid), 32'h1);
        enable = 1'b1; mem_valid = 1'b0; idb.id_ready = 1'b0;

        // Async reset with two entries queued.
        @(negedge clock); #2;
        check("two_addr", 32'(i_addr), 32'h01);
        check("two_valid", 32'(idb.id_valid), 32'h1);
        #1; reset = 1'b0;
        #1;
        check("arst_valid", 32'(idb.id_valid), 32'h0);
        check("arst_addr", 32'(i_addr), 32'h00);
        check("arst_full", 32'(full), 32'h0);
        @(negedge clock); #2;
        reset = 1'b1; idb.id_ready = 1'b1;

        // Every opcode against both flag polarities; model checks redirect and pc.
        for (int k = 0; k < 9; k++) begin
            for (int f = 0; f < 2; f++) begin
                @(negedge clock); #2;
                mem_valid = 1'b1;
                mem_ir = {ops[k], 11'h5A5};
                {zf, nf, cf} = (f == 0) ? 3'b000 : 3'b111;
                reg_C = 16'h0300 + IR_W'(k * 8) + IR_W'(f);
                @(negedge clock); #2;
                mem_valid = 1'b0;
            end
        end

        repeat (3) @(negedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage; successor to the single-register IF stage.
- Generates the instruction address and resolves branch/jump redirects from the MEM-stage instruction and the ALU flags.
- Buffers fetched instructions in a DEPTH-entry queue so fetch can keep running while decode stalls.
- Sits between the asynchronous-read instruction ROM and the ID stage. Presents instruction plus PC to ID with a valid/ready handshake.

Parameters:
- PC_W, 8: program counter / instruction address width.
- IR_W, 16: instruction width.
- OP_W, 5: opcode field width, taken from mem_ir[IR_W-1 -: OP_W]. Opcode encodings come from the project opcode definitions (BZ, BN, JUMP, JMPR, BNZ, BNN, BC, BNC).
- DEPTH, 4: queue entries; power of two, >=2.
- RESET_PC, 0: PC value after reset.
- NOP, 0: instruction word driven on id_ir when the queue is empty.

Ports:
- clock  in  1  Single clock, rising edge.
- reset  in  1  Asynchronous, active-low reset.
- enable  in  1  CPU in exec state. When low, all state holds.
- i_datain  in  IR_W  ROM data for address i_addr, valid in the same cycle.
- i_addr  out  PC_W  Fetch address; equals pc.
- mem_valid  in  1  mem_ir holds a real (non-squashed) instruction.
- mem_ir  in  IR_W  Instruction in the MEM stage.
- reg_C  in  IR_W  Branch target register; low PC_W bits are used.
- zf, nf, cf  in  1 each  Zero, negative and carry flags.
- id_ready  in  1  ID accepts the head entry this cycle.
- id_valid  out  1  Queue non-empty.
- id_ir  out  IR_W  Head instruction, or NOP when empty.
- id_pc  out  PC_W  Head instruction address, or 0 when empty.
- redirect  out  1  Combinational; high in the cycle a taken branch is resolved. Used to squash downstream stages.
- full  out  1  Queue count == DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC; read/write pointers=0; count=0; id_valid=0; id_ir=NOP; id_pc=0; full=0.
- i_addr = pc combinationally. No wait states.
- taken = enable & mem_valid & one of:
  - op==JUMP or op==JMPR
  - op==BZ & zf, or op==BNZ & !zf
  - op==BN & nf, or op==BNN & !nf
  - op==BC & cf, or op==BNC & !cf
- redirect = taken.
- Per rising edge, in priority order:
  1. enable=0: nothing changes (pc, queue, pointers hold).
  2. taken: pc <= reg_C[PC_W-1:0]; queue flushed (count=0, pointers reset to 0); no push and no pop this cycle. The head is squashed even if id_ready=1.
  3. Otherwise:
     - push = !full: store {pc, i_datain} at wr_ptr; wr_ptr++; pc <= pc+1.
     - pop = id_valid & id_ready: rd_ptr++.
     - count += push - pop. A simultaneous push and pop leaves count unchanged.
- Full: no push and pc holds. Fetch resumes the cycle after a pop makes room, because full is registered.
- Empty: id_valid=0 and id_ir=NOP. A pushed entry is visible on id_* the next cycle; fetch-to-ID latency is 1 cycle.
- Pointers wrap modulo DEPTH.
- pc arithmetic is modulo 2^PC_W: all-ones + 1 -> 0.
- A target with reg_C bits above PC_W is truncated.
- Branch evaluation does not depend on queue state. A branch resolved while the queue is full still redirects.
- Reset asserted mid-operation discards queue contents and any pending redirect immediately.
- Outputs id_ir, id_pc and id_valid come from registered state; they are not combinational from i_datain.

Test Plan:
- Reset then enable=1, id_ready=1, ROM word = 0x1000+addr -> i_addr 0,1,2…; id_valid high from cycle 2; id_ir=0x1000 with id_pc=0, then 0x1001 with id_pc=1, …
- DEPTH=4, id_ready=0 for 6 cycles -> 4 pushes (pc 0..3), full=1, pc holds at 4. Raise id_ready for 1 cycle -> pops 0x1000; full drops; next cycle pushes pc 4.
- mem_valid=1, mem_ir opcode BZ, zf=1, reg_C=0x0040 with 3 entries queued -> redirect=1 that cycle. Next edge: pc=0x40, id_valid=0. Next cycle the entry pushed has id_pc=0x40.
- BNZ with zf=1, BC with cf=0, and BZ with mem_valid=0 -> redirect=0; sequential fetch continues.
- pc preset to 0xFF (PC_W=8) by a jump -> next pc 0x00, no X.
- enable=0 for 3 cycles mid-stream with id_ready=1 -> pc, id_* and count frozen.
- Drop reset with 2 entries queued -> immediate id_valid=0, pc=RESET_PC.
